// File: rtl/gpr_trace_pkg.sv
// Shared types and width helpers for the GPR commit tracer.
package gpr_trace_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREGS = 32;
   localparam int unsigned IDXW  = $clog2(NREGS);

   // Commit record at the default configuration; the top rebuilds the same
   // layout from its own parameters so widths always agree with rec_width().
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [IDXW-1:0] rd;
      logic [XLEN-1:0] wdata;
      logic [31:0]     seq;
   } commit_rec_t;

   function automatic int unsigned idx_width(input int unsigned nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

   function automatic int unsigned rec_width(input int unsigned xlen, input int unsigned nregs);
      return xlen + 32 + 1 + idx_width(nregs) + xlen + 32;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with extra-MSB pointers.
module trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Status flags and gated handshakes; pop on empty and push on full are dropped.
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      rdata   = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Storage and pointers; storage is cleared so the head reads 0 out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/gpr_commit_tracer.sv
// Shadow GPR file plus buffered commit records for the trace consumer.
module gpr_commit_tracer
   import gpr_trace_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREGS = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     commit_valid,
   output logic                     commit_ready,
   input  logic [XLEN-1:0]          commit_pc,
   input  logic [31:0]              commit_inst,
   input  logic                     commit_wen,
   input  logic [$clog2(NREGS)-1:0] commit_rd,
   input  logic [XLEN-1:0]          commit_wdata,
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic [XLEN-1:0]          rec_pc,
   output logic [31:0]              rec_inst,
   output logic                     rec_wen,
   output logic [$clog2(NREGS)-1:0] rec_rd,
   output logic [XLEN-1:0]          rec_wdata,
   output logic [31:0]              rec_seq,
   input  logic [$clog2(NREGS)-1:0] dbg_idx,
   output logic [XLEN-1:0]          dbg_data,
   output logic [63:0]              retired,
   output logic                     overflow
);

   localparam int unsigned IW = $clog2(NREGS);
   localparam int unsigned RW = rec_width(XLEN, NREGS);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [IW-1:0]   rd;
      logic [XLEN-1:0] wdata;
      logic [31:0]     seq;
   } rec_t;

   rec_t            push_rec, head_rec;
   logic [RW-1:0]   head_bits;
   logic            fifo_full, fifo_empty, accept;
   logic [63:0]     retired_q;
   logic            overflow_q;
   logic [XLEN-1:0] shadow_q [NREGS];

   // Handshake and record assembly; ready depends only on FIFO state.
   always_comb begin
      commit_ready   = !fifo_full;
      accept         = commit_valid && !fifo_full;
      push_rec.pc    = commit_pc;
      push_rec.inst  = commit_inst;
      push_rec.wen   = commit_wen;
      push_rec.rd    = commit_rd;
      push_rec.wdata = commit_wdata;
      push_rec.seq   = retired_q[31:0];
   end

   trace_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .wdata (push_rec),
      .pop   (rec_ready),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head record fields and debug read; x0 is never written so it stays 0.
   always_comb begin
      head_rec  = head_bits;
      rec_valid = !fifo_empty;
      rec_pc    = head_rec.pc;
      rec_inst  = head_rec.inst;
      rec_wen   = head_rec.wen;
      rec_rd    = head_rec.rd;
      rec_wdata = head_rec.wdata;
      rec_seq   = head_rec.seq;
      dbg_data  = shadow_q[dbg_idx];
      retired   = retired_q;
      overflow  = overflow_q;
   end

   // Retirement counter and sticky overflow flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) retired_q <= retired_q + 64'd1;
         if (commit_valid && fifo_full) overflow_q <= 1'b1;
      end
   end

   // Shadow register file, written only by accepted commits to rd != 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) shadow_q[i] <= '0;
      end else if (accept && commit_wen && (commit_rd != '0)) begin
         shadow_q[commit_rd] <= commit_wdata;
      end
   end

endmodule
